// File: rtl/dmem_bist.sv
// March-test BIST initiator for the data memory: six fixed march elements,
// stops at the first miscompare and latches address, read data and element.
module dmem_bist #(
  parameter int                ADDR_W  = 12,
  parameter int                DATA_W  = 32,
  parameter int                DEPTH   = 4096,
  parameter logic [DATA_W-1:0] PATTERN = 32'hA5A5_A5A5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [2:0]        fail_elem,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, M0, M1, M2, M3, M4, M5} state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   a, a_nx;
  logic                done_nx, pass_nx;
  logic [ADDR_W-1:0]   fail_addr_nx;
  logic [DATA_W-1:0]   fail_data_nx;
  logic [2:0]          fail_elem_nx;

  logic                is_up, rd_en, wr_en, last, miscompare;
  logic [DATA_W-1:0]   wr_val, exp_val, a_pat;
  logic [2:0]          elem;

  assign a_pat = DATA_W'(a) ^ PATTERN;

  // Per-element decode: direction, read expectation, write data.
  always_comb begin
    is_up   = 1'b1;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    wr_val  = '0;
    exp_val = '0;
    elem    = 3'd0;
    unique case (state)
      M0: begin
        wr_en = 1'b1;
        elem  = 3'd0;
      end
      M1: begin
        rd_en  = 1'b1;
        wr_en  = 1'b1;
        wr_val = '1;
        elem   = 3'd1;
      end
      M2: begin
        is_up   = 1'b0;
        rd_en   = 1'b1;
        exp_val = '1;
        wr_en   = 1'b1;
        elem    = 3'd2;
      end
      M3: begin
        is_up = 1'b0;
        rd_en = 1'b1;
        elem  = 3'd3;
      end
      M4: begin
        wr_en  = 1'b1;
        wr_val = a_pat;
        elem   = 3'd4;
      end
      M5: begin
        rd_en   = 1'b1;
        exp_val = a_pat;
        elem    = 3'd5;
      end
      default: ;
    endcase
  end

  assign last       = is_up ? (a == LAST) : (a == '0);
  assign miscompare = rd_en && (mem_rd != exp_val);

  assign busy     = (state != IDLE);
  assign mem_we   = wr_en;
  assign mem_addr = busy ? a : '0;
  assign mem_wd   = wr_en ? wr_val : '0;

  always_comb begin
    state_nx     = state;
    a_nx         = a;
    done_nx      = done;
    pass_nx      = pass;
    fail_addr_nx = fail_addr;
    fail_data_nx = fail_data;
    fail_elem_nx = fail_elem;
    if (state == IDLE) begin
      if (start) begin
        state_nx     = M0;
        a_nx         = '0;
        done_nx      = 1'b0;
        pass_nx      = 1'b0;
        fail_addr_nx = '0;
        fail_data_nx = '0;
        fail_elem_nx = '0;
      end
    end else if (miscompare) begin
      // A read+write element still writes on this edge; only the walk stops.
      fail_addr_nx = a;
      fail_data_nx = mem_rd;
      fail_elem_nx = elem;
      pass_nx      = 1'b0;
      done_nx      = 1'b1;
      state_nx     = IDLE;
      a_nx         = '0;
    end else if (last) begin
      unique case (state)
        M0: begin state_nx = M1; a_nx = '0;   end
        M1: begin state_nx = M2; a_nx = LAST; end
        M2: begin state_nx = M3; a_nx = LAST; end
        M3: begin state_nx = M4; a_nx = '0;   end
        M4: begin state_nx = M5; a_nx = '0;   end
        M5: begin
          state_nx = IDLE;
          a_nx     = '0;
          done_nx  = 1'b1;
          pass_nx  = 1'b1;
        end
        default: ;
      endcase
    end else begin
      a_nx = is_up ? a + 1'b1 : a - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      a         <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
      fail_elem <= '0;
    end else begin
      state     <= state_nx;
      a         <= a_nx;
      done      <= done_nx;
      pass      <= pass_nx;
      fail_addr <= fail_addr_nx;
      fail_data <= fail_data_nx;
      fail_elem <= fail_elem_nx;
    end
  end

endmodule

// File: tb/tb_dmem_bist.sv
// Bench for dmem_bist at DEPTH=16: faultable memory model, march reference
// model feeding a scoreboard queue, and a monitor that checks each verdict.
module tb_dmem_bist;
  localparam int          AW    = 12;
  localparam int          DW    = 32;
  localparam int          DEPTH = 16;
  localparam logic [31:0] PAT   = 32'hA5A5_A5A5;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, pass, mem_we;
  logic [AW-1:0] fail_addr, mem_addr;
  logic [DW-1:0] fail_data, mem_wd, mem_rd;
  logic [2:0]    fail_elem;

  dmem_bist #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .PATTERN(PAT)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .pass(pass), .fail_addr(fail_addr), .fail_data(fail_data),
    .fail_elem(fail_elem), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clock = ~clock;

  // Memory model with optional faults: address bit 2 ignored, one stuck bit.
  logic [31:0] mem [DEPTH];
  bit          alias_en = 1'b0, stuck_en = 1'b0, stuck_val = 1'b0;
  logic [3:0]  stuck_word = '0;
  logic [4:0]  stuck_bit = '0;
  logic [3:0]  phys;

  always_comb begin
    phys   = alias_en ? (mem_addr[3:0] & 4'b1011) : mem_addr[3:0];
    mem_rd = mem[phys];
    if (stuck_en && phys == stuck_word)
      mem_rd = stuck_val ? (mem_rd | (32'd1 << stuck_bit)) : (mem_rd & ~(32'd1 << stuck_bit));
  end

  always @(posedge clock) if (mem_we) mem[phys] <= mem_wd;

  typedef struct {
    bit          pass;
    logic [11:0] addr;
    logic [31:0] data;
    logic [2:0]  elem;
    int          cycles;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: walk the six march elements over an abstract memory.
  function automatic exp_t ref_run();
    exp_t        r;
    logic [31:0] m [DEPTH];
    logic [31:0] got, expv, patv;
    int          ad, p;
    bit          rd;
    r = '{pass: 1'b0, addr: '0, data: '0, elem: '0, cycles: 0};
    foreach (m[i]) m[i] = '0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < DEPTH; i++) begin
        ad   = (e == 2 || e == 3) ? DEPTH - 1 - i : i;
        p    = alias_en ? (ad & 11) : ad;
        patv = 32'(ad) ^ PAT;
        r.cycles++;
        rd   = (e == 1 || e == 2 || e == 3 || e == 5);
        if (rd) begin
          expv = (e == 2) ? 32'hFFFF_FFFF : (e == 5) ? patv : 32'h0;
          got  = m[p];
          if (stuck_en && p == int'(stuck_word))
            got = stuck_val ? (got | (32'd1 << stuck_bit)) : (got & ~(32'd1 << stuck_bit));
          if (got != expv) begin
            r.addr = 12'(ad);
            r.data = got;
            r.elem = 3'(e);
            return r;
          end
        end
        if (e == 0 || e == 2) m[p] = 32'h0;
        else if (e == 1)      m[p] = 32'hFFFF_FFFF;
        else if (e == 4)      m[p] = patv;
      end
    end
    r.pass = 1'b1;
    return r;
  endfunction

  // Monitor: counts busy cycles and checks each done rise against the queue.
  int busy_cnt = 0;
  bit prev_done = 1'b0;
  always @(negedge clock) begin
    if (!reset_n) begin
      busy_cnt  = 0;
      prev_done = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (busy && done) begin
        checks++; errors++;
        $display("FAIL busy_done_excl: busy=1 done=1 at %0t", $time);
      end
      if (done && !prev_done) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: done rose with empty queue at %0t", $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("pass",        64'(pass),      64'(e.pass));
          chk("fail_addr",   64'(fail_addr), 64'(e.addr));
          chk("fail_data",   64'(fail_data), 64'(e.data));
          chk("fail_elem",   64'(fail_elem), 64'(e.elem));
          chk("busy_cycles", 64'(busy_cnt),  64'(e.cycles));
        end
        busy_cnt = 0;
      end
      prev_done = done;
    end
  end

  task automatic wait_done();
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (done) break;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout: done=%0b required 1", done);
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic do_run(input bit m2_start, input bit m3_reset);
    if (!m3_reset) exp_q.push_back(ref_run());
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("start_busy",      64'(busy),      64'd1);
    chk("start_done_clr",  64'(done),      64'd0);
    chk("start_pass_clr",  64'(pass),      64'd0);
    chk("start_faddr_clr", 64'(fail_addr), 64'd0);
    chk("start_fdata_clr", 64'(fail_data), 64'd0);
    chk("start_felem_clr", 64'(fail_elem), 64'd0);
    chk("start_addr",      64'(mem_addr),  64'd0);
    chk("start_we",        64'(mem_we),    64'd1);
    if (m2_start) begin
      repeat (36) @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      chk("m2_start_busy", 64'(busy), 64'd1);
    end
    if (m3_reset) begin
      repeat (55) @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_busy",  64'(busy),     64'd0);
      chk("rst_done",  64'(done),     64'd0);
      chk("rst_we",    64'(mem_we),   64'd0);
      chk("rst_addr",  64'(mem_addr), 64'd0);
      chk("rst_pass",  64'(pass),     64'd0);
      @(negedge clock);
      #2 reset_n = 1'b1;
      repeat (2) @(negedge clock);
    end else begin
      wait_done();
    end
  endtask

  initial begin
    foreach (mem[i]) mem[i] = $urandom;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clock);
    chk("reset_busy",  64'(busy),      64'd0);
    chk("reset_done",  64'(done),      64'd0);
    chk("reset_pass",  64'(pass),      64'd0);
    chk("reset_faddr", 64'(fail_addr), 64'd0);
    chk("reset_fdata", 64'(fail_data), 64'd0);
    chk("reset_felem", 64'(fail_elem), 64'd0);
    chk("reset_we",    64'(mem_we),    64'd0);
    chk("reset_addr",  64'(mem_addr),  64'd0);
    chk("reset_wd",    64'(mem_wd),    64'd0);
    #2 reset_n = 1'b1;

    do_run(1'b0, 1'b0);
    for (int k = 0; k < DEPTH; k++)
      chk("final_mem", 64'(mem[k]), 64'(32'(k) ^ PAT));

    stuck_en = 1'b1; stuck_word = 4'd5; stuck_bit = 5'd3; stuck_val = 1'b1;
    do_run(1'b0, 1'b0);
    chk("stuck_addr", 64'(fail_addr), 64'd5);
    chk("stuck_data", 64'(fail_data), 64'h8);
    chk("stuck_elem", 64'(fail_elem), 64'd1);

    stuck_en = 1'b0;
    do_run(1'b0, 1'b0);

    alias_en = 1'b1;
    do_run(1'b0, 1'b0);
    chk("alias_addr", 64'(fail_addr), 64'd4);
    chk("alias_data", 64'(fail_data), 64'hFFFF_FFFF);
    chk("alias_elem", 64'(fail_elem), 64'd1);

    alias_en = 1'b0;
    do_run(1'b1, 1'b0);
    do_run(1'b0, 1'b1);

    for (int n = 0; n < 8; n++) begin
      alias_en   = ($urandom_range(0, 3) == 0);
      stuck_en   = ($urandom_range(0, 3) != 0);
      stuck_word = 4'($urandom_range(0, 15));
      stuck_bit  = 5'($urandom_range(0, 31));
      stuck_val  = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 5)) @(negedge clock);
      do_run(1'b0, 1'b0);
    end

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
